// File: rtl/relogio_pkg.sv
// Shared definitions for the digital clock digits: active-low 7-segment
// patterns packed as {a,b,c,d,e,f,g}, mode encodings and digit arithmetic.
package relogio_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic MODO_RUN = 1'b0;
  localparam logic MODO_SET = 1'b1;

  // Increment a digit, wrapping from modulo-1 back to 0.
  function automatic logic [3:0] next_digit(input logic [3:0] value, input int modulo);
    if (value == 4'(modulo - 1)) begin
      return 4'd0;
    end
    return value + 4'd1;
  endfunction

endpackage

// File: rtl/segundos_dezena_if.sv
// Carry chain and display bundle of one clock digit: the carry coming from
// the previous stage, the carry toward the next stage and the display drive.
interface segundos_dezena_if;
  logic       carry_in;
  logic       clockOUT;
  logic [3:0] digit;
  logic       a, b, c, d, e, f, g;

  // The counting stage itself.
  modport master (
    input  carry_in,
    output clockOUT, digit, a, b, c, d, e, f, g
  );

  // Whatever feeds the carry and watches the display/carry out.
  modport slave (
    output carry_in,
    input  clockOUT, digit, a, b, c, d, e, f, g
  );
endinterface

// File: rtl/seg7_decod.sv
// Binary digit to active-low 7-segment decoder, shared by every clock digit.
// Values 10..15 blank the display.
module seg7_decod
  import relogio_pkg::*;
(
  input  logic [3:0] digit,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g
);

  logic [6:0] seg;

  // Pattern lookup; anything outside 0..9 shows nothing.
  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

  assign {a, b, c, d, e, f, g} = seg;

endmodule

// File: rtl/segundos_dezena.sv
// Tens-of-seconds digit: counts carry edges from the units stage in run mode,
// counts debounced KEY1 presses in set mode, and emits a one-cycle carry to
// the minutes stage on a run-mode wrap.
module segundos_dezena
  import relogio_pkg::*;
#(
  parameter int MODULO          = 6,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic              clock,
  input  logic              KEY0,
  input  logic              SW17,
  input  logic              KEY1,
  segundos_dezena_if.master bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] key_sync_reg, key_sync_next;
  logic [SYNC_STAGES-1:0] sw_sync_reg, sw_sync_next;
  logic                   key_s;
  logic                   mode;

  logic                   key_db_reg, key_db_next;
  logic [CNT_W-1:0]       db_cnt_reg, db_cnt_next;
  logic                   press;

  logic                   carry_d_reg;
  logic                   carry_evt;

  logic [3:0]             digit_reg, digit_next;
  logic                   clock_out_reg, clock_out_next;

  logic                   seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;

  // Synchroniser chains: stage 0 samples the pin, each later stage copies the one before.
  assign key_sync_next[0] = KEY1;
  assign sw_sync_next[0]  = SW17;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    assign key_sync_next[gi] = key_sync_reg[gi-1];
    assign sw_sync_next[gi]  = sw_sync_reg[gi-1];
  end

  assign key_s = key_sync_reg[SYNC_STAGES-1];
  assign mode  = sw_sync_reg[SYNC_STAGES-1];

  // Synchroniser registers, preset to the idle levels (key released, run mode).
  always_ff @(posedge clock or negedge KEY0) begin
    if (!KEY0) begin
      key_sync_reg <= '1;
      sw_sync_reg  <= {SYNC_STAGES{MODO_RUN}};
    end else begin
      key_sync_reg <= key_sync_next;
      sw_sync_reg  <= sw_sync_next;
    end
  end

  // Debounce: the stable level follows the synced key only after it has
  // disagreed for DEBOUNCE_CYCLES consecutive cycles; a falling stable level
  // is the press strobe.
  always_comb begin
    key_db_next = key_db_reg;
    db_cnt_next = db_cnt_reg;
    press       = 1'b0;
    if (key_s == key_db_reg) begin
      db_cnt_next = '0;
    end else if (db_cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      key_db_next = key_s;
      db_cnt_next = '0;
      press       = ~key_s;
    end else begin
      db_cnt_next = db_cnt_reg + 1'b1;
    end
  end

  // Debounce state; reset abandons any press being qualified.
  always_ff @(posedge clock or negedge KEY0) begin
    if (!KEY0) begin
      key_db_reg <= 1'b1;
      db_cnt_reg <= '0;
    end else begin
      key_db_reg <= key_db_next;
      db_cnt_reg <= db_cnt_next;
    end
  end

  // Rising edge of the units carry; a level held high counts once.
  assign carry_evt = bus.carry_in & ~carry_d_reg;

  // Carry edge register, preset high so a carry already high at reset release is ignored.
  always_ff @(posedge clock or negedge KEY0) begin
    if (!KEY0) begin
      carry_d_reg <= 1'b1;
    end else begin
      carry_d_reg <= bus.carry_in;
    end
  end

  // Digit update: only the event belonging to the current mode is acted on;
  // the carry out fires only on a run-mode wrap.
  always_comb begin
    digit_next     = digit_reg;
    clock_out_next = 1'b0;
    if (mode == MODO_RUN) begin
      if (carry_evt) begin
        digit_next     = next_digit(digit_reg, MODULO);
        clock_out_next = (digit_reg == 4'(MODULO - 1));
      end
    end else if (mode == MODO_SET && press) begin
      digit_next = next_digit(digit_reg, MODULO);
    end
  end

  // Digit and carry-out registers; reset clears both without waiting for a clock.
  always_ff @(posedge clock or negedge KEY0) begin
    if (!KEY0) begin
      digit_reg     <= 4'd0;
      clock_out_reg <= 1'b0;
    end else begin
      digit_reg     <= digit_next;
      clock_out_reg <= clock_out_next;
    end
  end

  seg7_decod u_decod (
    .digit (digit_reg),
    .a     (seg_a),
    .b     (seg_b),
    .c     (seg_c),
    .d     (seg_d),
    .e     (seg_e),
    .f     (seg_f),
    .g     (seg_g)
  );

  assign bus.digit    = digit_reg;
  assign bus.clockOUT = clock_out_reg;
  assign bus.a        = seg_a;
  assign bus.b        = seg_b;
  assign bus.c        = seg_c;
  assign bus.d        = seg_d;
  assign bus.e        = seg_e;
  assign bus.f        = seg_f;
  assign bus.g        = seg_g;

endmodule

// File: tb/tb_segundos_dezena.sv
// Bench for segundos_dezena: a MODULO=6 and a MODULO=10 instance share all
// stimulus; a behavioural model is compared against both every cycle, and
// directed phases add literal expectations.
module tb_segundos_dezena;

  localparam int DEB  = 4;
  localparam int SYNC = 2;

  logic clock    = 1'b0;
  logic KEY0     = 1'b0;
  logic SW17     = 1'b0;
  logic KEY1     = 1'b1;
  logic carry_in = 1'b0;

  int tests = 0;
  int fails = 0;

  segundos_dezena_if bus6 ();
  segundos_dezena_if bus10 ();

  assign bus6.carry_in  = carry_in;
  assign bus10.carry_in = carry_in;

  segundos_dezena #(.MODULO(6), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut6 (
    .clock (clock),
    .KEY0  (KEY0),
    .SW17  (SW17),
    .KEY1  (KEY1),
    .bus   (bus6)
  );

  segundos_dezena #(.MODULO(10), .DEBOUNCE_CYCLES(DEB), .SYNC_STAGES(SYNC)) dut10 (
    .clock (clock),
    .KEY0  (KEY0),
    .SW17  (SW17),
    .KEY1  (KEY1),
    .bus   (bus10)
  );

  always #5 clock = ~clock;

  wire [6:0] seg6  = {bus6.a, bus6.b, bus6.c, bus6.d, bus6.e, bus6.f, bus6.g};
  wire [6:0] seg10 = {bus10.a, bus10.b, bus10.c, bus10.d, bus10.e, bus10.f, bus10.g};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Display pattern {a..g} for a digit value, straight from the segment table.
  function automatic logic [6:0] exp_seg(input int v);
    case (v)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  int m_swq[$];
  int m_keyq[$];
  int m_db, m_run, m_mode, m_ks;
  bit m_prev, m_press, m_cev;
  int m_dig6, m_dig10;
  bit m_co6, m_co10;

  task automatic m_reset();
    m_swq  = {};
    m_keyq = {};
    for (int i = 0; i < SYNC; i++) begin
      m_swq.push_back(0);
      m_keyq.push_back(1);
    end
    m_db    = 1;
    m_run   = 0;
    m_prev  = 1'b1;
    m_dig6  = 0;
    m_dig10 = 0;
    m_co6   = 1'b0;
    m_co10  = 1'b0;
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clock or negedge KEY0);
      if (!KEY0) begin
        m_reset();
      end else begin
        // Pin levels reach the logic SYNC clocks after being sampled.
        m_mode = m_swq.pop_front();
        m_swq.push_back(int'(SW17));
        m_ks = m_keyq.pop_front();
        m_keyq.push_back(int'(KEY1));
        // Stable key level changes after DEB consecutive disagreeing cycles.
        m_press = 1'b0;
        if (m_ks == m_db) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == DEB) begin
            m_db    = m_ks;
            m_run   = 0;
            m_press = (m_ks == 0);
          end
        end
        m_cev  = carry_in && !m_prev;
        m_prev = carry_in;
        m_co6  = 1'b0;
        m_co10 = 1'b0;
        if (m_mode == 0) begin
          if (m_cev) begin
            m_co6   = (m_dig6 == 5);
            m_co10  = (m_dig10 == 9);
            m_dig6  = (m_dig6 + 1) % 6;
            m_dig10 = (m_dig10 + 1) % 10;
          end
        end else if (m_press) begin
          m_dig6  = (m_dig6 + 1) % 6;
          m_dig10 = (m_dig10 + 1) % 10;
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clock);
      check("cyc_digit6", bus6.digit, m_dig6);
      check("cyc_co6", bus6.clockOUT, m_co6);
      check("cyc_seg6", seg6, exp_seg(m_dig6));
      check("cyc_digit10", bus10.digit, m_dig10);
      check("cyc_co10", bus10.clockOUT, m_co10);
      check("cyc_seg10", seg10, exp_seg(m_dig10));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic key_phase(input logic level, input int n);
    KEY1 = level;
    cycles(n);
  endtask

  int key_left;

  // ---------------- stimulus ----------------
  initial begin
    cycles(2);
    check("lit_reset_digit", bus6.digit, 4'd0);
    check("lit_reset_seg", seg6, 7'b0000001);
    check("lit_reset_co", bus6.clockOUT, 1'b0);
    KEY0 = 1'b1;
    cycles(2);

    // Five single-cycle carry pulses: one step each, no carry out.
    for (int i = 1; i <= 5; i++) begin
      carry_in = 1'b1;
      cycles(1);
      check("lit_count_digit", bus6.digit, i);
      check("lit_count_co", bus6.clockOUT, 1'b0);
      carry_in = 1'b0;
      cycles(1);
    end
    check("lit_seg5", seg6, 7'b0100100);

    // Wrap 5 -> 0 with a single-cycle carry out.
    carry_in = 1'b1;
    cycles(1);
    check("lit_wrap_digit", bus6.digit, 4'd0);
    check("lit_wrap_co", bus6.clockOUT, 1'b1);
    check("lit_wrap_seg", seg6, 7'b0000001);
    carry_in = 1'b0;
    cycles(1);
    check("lit_wrap_co_drop", bus6.clockOUT, 1'b0);

    // Held carry counts once; high at reset release counts never.
    carry_in = 1'b1;
    cycles(50);
    check("lit_held_digit", bus6.digit, 4'd1);
    KEY0 = 1'b0;
    cycles(1);
    KEY0 = 1'b1;
    cycles(5);
    check("lit_held_reset_digit", bus6.digit, 4'd0);
    carry_in = 1'b0;
    cycles(2);

    // Set mode: glitches ignored, one clean press counts once.
    SW17 = 1'b1;
    cycles(3);
    key_phase(1'b0, 2);
    key_phase(1'b1, 2);
    key_phase(1'b0, 2);
    key_phase(1'b1, 3);
    key_phase(1'b0, 10);
    key_phase(1'b1, 10);
    check("lit_press_digit", bus6.digit, 4'd1);
    for (int i = 0; i < 5; i++) begin
      key_phase(1'b0, 8);
      key_phase(1'b1, 8);
    end
    check("lit_set_wrap6", bus6.digit, 4'd0);
    check("lit_set_wrap10", bus10.digit, 4'd6);
    for (int i = 0; i < 3; i++) begin
      carry_in = 1'b1;
      cycles(1);
      carry_in = 1'b0;
      cycles(1);
    end
    check("lit_set_carry_drop", bus6.digit, 4'd0);

    // Back to run mode, count to 3, reset between clock edges.
    SW17 = 1'b0;
    cycles(3);
    for (int i = 0; i < 3; i++) begin
      carry_in = 1'b1;
      cycles(1);
      carry_in = 1'b0;
      cycles(1);
    end
    check("lit_pre_reset_digit", bus6.digit, 4'd3);
    @(posedge clock);
    #2 KEY0 = 1'b0;
    #1;
    check("lit_async_digit", bus6.digit, 4'd0);
    check("lit_async_seg", seg6, 7'b0000001);
    @(negedge clock);
    KEY0 = 1'b1;
    cycles(2);

    // MODULO=10 instance: nine steps, then the 9 -> 0 wrap pulses, then reset kills the pulse.
    for (int i = 0; i < 9; i++) begin
      carry_in = 1'b1;
      cycles(1);
      carry_in = 1'b0;
      cycles(1);
    end
    check("lit_dig10_nine", bus10.digit, 4'd9);
    carry_in = 1'b1;
    @(posedge clock);
    #1;
    check("lit_wrap10_co", bus10.clockOUT, 1'b1);
    check("lit_wrap10_digit", bus10.digit, 4'd0);
    KEY0 = 1'b0;
    #1;
    check("lit_pulse_reset_co", bus10.clockOUT, 1'b0);
    @(negedge clock);
    carry_in = 1'b0;
    KEY0 = 1'b1;
    cycles(2);

    // Randomised traffic: carries, key runs, mode toggles and rare resets.
    key_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (key_left == 0) begin
        KEY1     = 1'($urandom_range(0, 1));
        key_left = $urandom_range(1, 10);
      end
      key_left--;
      if ($urandom_range(0, 99) < 3) SW17 = ~SW17;
      carry_in = ($urandom_range(0, 3) == 0);
      KEY0     = ($urandom_range(0, 599) != 0);
      cycles(1);
    end
    KEY0 = 1'b1;
    cycles(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
